// File: rtl/bm_resp_pkg.sv
// Shared types and constants for the board-manager response transmitter.
package bm_resp_pkg;

  typedef enum logic [1:0] {
    RESP_RSVD = 2'd0,
    RESP_RD   = 2'd1,
    RESP_WACK = 2'd2,
    RESP_ERR  = 2'd3
  } resp_type_e;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned FRAME_LEN = 10;

  // Top-level frame sequencer states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  typedef struct packed {
    resp_type_e  rtype;
    logic [23:0] addr;
    logic [31:0] data;
  } resp_t;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

  // Lay out one response as a wire frame; the last byte zeroes the B1..B9 sum.
  function automatic frame_t build_frame(input resp_t r);
    frame_t     f;
    logic [7:0] sum;
    f[0] = SYNC_BYTE;
    f[1] = {6'b0, r.rtype};
    f[2] = r.addr[7:0];
    f[3] = r.addr[15:8];
    f[4] = r.addr[23:16];
    f[5] = r.data[7:0];
    f[6] = r.data[15:8];
    f[7] = r.data[23:16];
    f[8] = r.data[31:24];
    sum  = 8'd0;
    for (int i = 1; i < 9; i++) begin
      sum = 8'(sum + f[i]);
    end
    f[9] = 8'(8'd0 - sum);
    return f;
  endfunction

endpackage

// File: rtl/bm_uart_tx_byte.sv
// 8N1 byte serializer; a start accepted in the final stop-bit clock chains bytes with no gap.
module bm_uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       start,
  output logic       tx,
  output logic       done_c
);

  localparam int unsigned      CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             tx_nxt;
  logic             bit_end_c;

  assign bit_end_c = (baud_cnt == CNT_LAST);
  assign done_c    = (state == S_STOP) && bit_end_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      tx       <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    tx_nxt       = tx;
    if (state != S_IDLE) begin
      baud_cnt_nxt = bit_end_c ? '0 : baud_cnt + CNT_W'(1);
    end
    case (state)
      S_IDLE: begin
        tx_nxt       = 1'b1;
        baud_cnt_nxt = '0;
        if (start) begin
          state_nxt = S_START;
          tx_nxt    = 1'b0;
          shreg_nxt = tx_byte;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
          tx_nxt      = shreg[0];
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = {1'b0, shreg[7:1]};
            tx_nxt      = shreg[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (start) begin
            state_nxt = S_START;
            tx_nxt    = 1'b0;
            shreg_nxt = tx_byte;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/bm_resp_tx.sv
// Board-manager response transmitter: response FIFO, frame builder and UART line driver.
module bm_resp_tx
  import bm_resp_pkg::*;
#(
  parameter int unsigned BAUD_DIV        = 50,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [1:0]  s_type,
  input  logic [23:0] s_addr,
  input  logic [31:0] s_data,
  input  logic        tx_enable,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned      DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned      PTR_W    = FIFO_DEPTH_LOG2;
  localparam int unsigned      OCC_W    = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned      IDX_W    = 4;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  resp_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ, occ_nxt;

  logic [1:0]       state, state_nxt;
  frame_t           frame, frame_nxt;
  logic [IDX_W-1:0] byte_idx, byte_idx_nxt;
  logic [IDX_W-1:0] idx_next_c;
  logic [15:0]      frame_count_nxt;

  logic             push_c, pop_c;
  logic             ser_start_c, ser_done_c;
  logic [7:0]       ser_byte_c;

  assign push_c     = s_valid & s_ready;
  assign pop_c      = (state == LOAD);
  assign idx_next_c = byte_idx + IDX_W'(1);

  // Response storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= resp_t'({s_type, s_addr, s_data});
    end
  end

  always_comb begin
    occ_nxt = occ;
    case ({push_c, pop_c})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ_nxt;
    end
  end

  // Frame sequencer; LOAD starts B0 directly so a back-to-back frame leaves two idle clocks
  always_comb begin
    state_nxt       = state;
    frame_nxt       = frame;
    byte_idx_nxt    = byte_idx;
    frame_count_nxt = frame_count;
    ser_start_c     = 1'b0;
    ser_byte_c      = SYNC_BYTE;
    case (state)
      IDLE: begin
        if ((occ != '0) && tx_enable) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        frame_nxt    = build_frame(mem[rd_ptr]);
        byte_idx_nxt = '0;
        ser_start_c  = 1'b1;
        ser_byte_c   = SYNC_BYTE;
        state_nxt    = SEND;
      end
      SEND: begin
        if (ser_done_c) begin
          if (byte_idx == IDX_LAST) begin
            frame_count_nxt = frame_count + 16'd1;
            state_nxt       = IDLE;
          end else begin
            ser_start_c  = 1'b1;
            ser_byte_c   = frame[idx_next_c];
            byte_idx_nxt = idx_next_c;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from next-state values so they track the current cycle exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame       <= '0;
      byte_idx    <= '0;
      frame_count <= '0;
      busy        <= 1'b0;
      s_ready     <= 1'b1;
    end else begin
      state       <= state_nxt;
      frame       <= frame_nxt;
      byte_idx    <= byte_idx_nxt;
      frame_count <= frame_count_nxt;
      busy        <= (state_nxt != IDLE) || (occ_nxt != '0);
      s_ready     <= (occ_nxt != OCC_FULL);
    end
  end

  bm_uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_byte(ser_byte_c),
    .start  (ser_start_c),
    .tx     (tx),
    .done_c (ser_done_c)
  );

endmodule
